// File: rtl/text_scene_typewriter.sv
// Typewriter-style text scene: reveals N_LINES x MAX_CHARS glyph slots one at a time
// from the alphabet ROM, then optionally blinks the last line.
//
// state  | meaning
// IDLE   | nothing revealed, text blanked
// REVEAL | slots appearing one per REVEAL_DIV cycles
// SHOWN  | all slots visible, last line may blink
module text_scene_typewriter #(
  parameter int           N_LINES    = 3,
  parameter int           MAX_CHARS  = 10,
  parameter int           GLYPH_W    = 15,
  parameter int           GLYPH_H    = 30,
  parameter int           IMG_W      = 405,
  parameter int           REVEAL_DIV = 5_000_000,
  parameter bit           BLINK_EN   = 1'b1,
  parameter int           BLINK_DIV  = 12_500_000,
  parameter logic [11:0]  BG_COLOR   = 12'hfff
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [9:0]                     h_cnt,
  input  logic [9:0]                     v_cnt,
  input  logic [N_LINES*MAX_CHARS*5-1:0] line_chars,
  input  logic [N_LINES*10-1:0]          line_h_start,
  input  logic [N_LINES*10-1:0]          line_v_start,
  input  logic [11:0]                    alpha_mem_vga_data,
  output logic [11:0]                    vga_data,
  output logic [16:0]                    pixel_addr,
  output logic                           busy,
  output logic                           done
);

  localparam int TOTAL = N_LINES * MAX_CHARS;
  localparam int DW    = (REVEAL_DIV > 1) ? $clog2(REVEAL_DIV) : 1;
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(REVEAL_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [7:0]    TOTAL_8    = 8'(TOTAL);
  localparam logic [10:0]   SPAN_X     = 11'(MAX_CHARS * GLYPH_W);
  localparam logic [10:0]   SPAN_Y     = 11'(GLYPH_H);
  localparam logic [2:0]    LAST_LINE  = 3'(N_LINES - 1);

  typedef enum logic [1:0] {IDLE, REVEAL, SHOWN} state_t;

  state_t        state, state_n;
  logic [7:0]    revealed, revealed_n;
  logic [DW-1:0] div_cnt, div_cnt_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          blink_on, blink_on_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      revealed  <= '0;
      div_cnt   <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      state     <= state_n;
      revealed  <= revealed_n;
      div_cnt   <= div_cnt_n;
      blink_cnt <= blink_cnt_n;
      blink_on  <= blink_on_n;
    end
  end

  always_comb begin
    state_n     = state;
    revealed_n  = revealed;
    div_cnt_n   = div_cnt;
    blink_cnt_n = blink_cnt;
    blink_on_n  = blink_on;
    if (start) begin
      // start overrides any pending increment, including the final one
      revealed_n  = 8'd1;
      div_cnt_n   = '0;
      blink_cnt_n = '0;
      blink_on_n  = 1'b1;
      state_n     = (TOTAL == 1) ? SHOWN : REVEAL;
    end else begin
      case (state)
        REVEAL: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt_n  = '0;
            revealed_n = revealed + 8'd1;
            if (revealed + 8'd1 == TOTAL_8) state_n = SHOWN;
          end else begin
            div_cnt_n = div_cnt + 1'b1;
          end
        end
        SHOWN: begin
          if (BLINK_EN) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt_n = '0;
              blink_on_n  = ~blink_on;
            end else begin
              blink_cnt_n = blink_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == REVEAL);
  assign done = (state == SHOWN);

  logic        hit;
  logic [2:0]  hit_line;
  logic [10:0] rel_x, rel_y, dx;
  logic [4:0]  slot_c;
  logic [7:0]  slot_idx;
  logic [4:0]  code;
  logic        visible;

  // Line hit test at 11 bits so a line near the right edge never wraps.
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    rel_x    = '0;
    rel_y    = '0;
    for (int l = 0; l < N_LINES; l++) begin
      if (!hit &&
          ({1'b0, h_cnt} >= {1'b0, line_h_start[l*10 +: 10]}) &&
          ({1'b0, h_cnt} <  {1'b0, line_h_start[l*10 +: 10]} + SPAN_X) &&
          ({1'b0, v_cnt} >= {1'b0, line_v_start[l*10 +: 10]}) &&
          ({1'b0, v_cnt} <  {1'b0, line_v_start[l*10 +: 10]} + SPAN_Y)) begin
        hit      = 1'b1;
        hit_line = 3'(l);
        rel_x    = {1'b0, h_cnt} - {1'b0, line_h_start[l*10 +: 10]};
        rel_y    = {1'b0, v_cnt} - {1'b0, line_v_start[l*10 +: 10]};
      end
    end
  end

  // Slot column by comparator chain instead of a divider.
  always_comb begin
    slot_c = '0;
    dx     = rel_x;
    for (int k = 1; k < MAX_CHARS; k++) begin
      if (rel_x >= 11'(k * GLYPH_W)) begin
        slot_c = 5'(k);
        dx     = rel_x - 11'(k * GLYPH_W);
      end
    end
  end

  assign slot_idx = 8'(hit_line) * 8'(MAX_CHARS) + 8'(slot_c);

  always_comb begin
    code = '0;
    for (int s = 0; s < TOTAL; s++) begin
      if (slot_idx == 8'(s)) code = line_chars[s*5 +: 5];
    end
  end

  assign visible = hit && (slot_idx < revealed) && (code != 5'd0) &&
                   !((hit_line == LAST_LINE) && !blink_on);

  always_comb begin
    pixel_addr = '0;
    vga_data   = BG_COLOR;
    if (visible) begin
      pixel_addr = 17'(rel_y) * 17'(IMG_W) + 17'(code) * 17'(GLYPH_W) + 17'(dx);
      vga_data   = alpha_mem_vga_data;
    end
  end

endmodule

// File: tb/tb_text_scene_typewriter.sv
// Scoreboard bench: stimulus pushes model predictions each cycle, a negedge monitor
// pops and compares against two DUTs (blink enabled and disabled).
module tb_text_scene_typewriter;

  localparam int NL = 2;
  localparam int MC = 3;
  localparam int GW = 15;
  localparam int GH = 30;
  localparam int IW = 405;
  localparam int RD = 4;
  localparam int BD = 8;
  localparam int TOT = NL * MC;
  localparam logic [11:0] BG = 12'hfff;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [9:0]        h_cnt, v_cnt;
  logic [NL*MC*5-1:0] line_chars;
  logic [NL*10-1:0]  line_h_start, line_v_start;
  logic [11:0]       rom1, rom2, vga1, vga2;
  logic [16:0]       addr1, addr2;
  logic              busy1, done1, busy2, done2;

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [16:0] a);
    logic [16:0] t;
    t = a * 17'd7 + 17'h123;
    return t[11:0];
  endfunction

  assign rom1 = rom_fn(addr1);
  assign rom2 = rom_fn(addr2);

  text_scene_typewriter #(.N_LINES(NL), .MAX_CHARS(MC), .GLYPH_W(GW), .GLYPH_H(GH), .IMG_W(IW),
    .REVEAL_DIV(RD), .BLINK_EN(1'b1), .BLINK_DIV(BD), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .start(start), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .line_chars(line_chars), .line_h_start(line_h_start), .line_v_start(line_v_start),
    .alpha_mem_vga_data(rom1), .vga_data(vga1), .pixel_addr(addr1), .busy(busy1), .done(done1));

  text_scene_typewriter #(.N_LINES(NL), .MAX_CHARS(MC), .GLYPH_W(GW), .GLYPH_H(GH), .IMG_W(IW),
    .REVEAL_DIV(RD), .BLINK_EN(1'b0), .BLINK_DIV(BD), .BG_COLOR(BG)) dut_nb (
    .clk(clk), .rst(rst), .start(start), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .line_chars(line_chars), .line_h_start(line_h_start), .line_v_start(line_v_start),
    .alpha_mem_vga_data(rom2), .vga_data(vga2), .pixel_addr(addr2), .busy(busy2), .done(done2));

  typedef struct {
    int          tag;
    logic [11:0] vga, vga2;
    logic [16:0] addr, addr2;
    logic        busy, done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_probe  = 0;

  // Reference model: cycles elapsed since the last start (0 = idle).
  int mdl_s = 0;
  int chars[NL][MC];
  int lhs[NL];
  int lvs[NL];

  function automatic int mdl_rev();
    int r;
    if (mdl_s == 0) return 0;
    r = 1 + (mdl_s - 1) / RD;
    return (r > TOT) ? TOT : r;
  endfunction

  function automatic bit mdl_done();
    return (mdl_s > 0) && ((mdl_s - 1) >= (TOT - 1) * RD);
  endfunction

  function automatic bit mdl_bon();
    if (!mdl_done()) return 1'b1;
    return (((mdl_s - 1 - (TOT - 1) * RD) / BD) % 2) == 0;
  endfunction

  function automatic void ref_pixel(input int h, input int v, input int rev, input bit bon,
                                    output logic [11:0] vga, output logic [16:0] addr);
    int c, dx, dy, code, a;
    vga  = BG;
    addr = '0;
    for (int l = 0; l < NL; l++) begin
      if (h >= lhs[l] && h < lhs[l] + MC * GW && v >= lvs[l] && v < lvs[l] + GH) begin
        c    = (h - lhs[l]) / GW;
        dx   = (h - lhs[l]) % GW;
        dy   = v - lvs[l];
        code = chars[l][c];
        if (l * MC + c < rev && code != 0 && !(l == NL - 1 && !bon)) begin
          a    = dy * IW + code * GW + dx;
          addr = a[16:0];
          vga  = rom_fn(addr);
        end
        return;
      end
    end
  endfunction

  task automatic apply_lines();
    for (int l = 0; l < NL; l++) begin
      for (int c = 0; c < MC; c++) line_chars[(l*MC+c)*5 +: 5] = 5'(chars[l][c]);
      line_h_start[l*10 +: 10] = 10'(lhs[l]);
      line_v_start[l*10 +: 10] = 10'(lvs[l]);
    end
  endtask

  task automatic tick(input bit st, input bit rs);
    start = st;
    rst   = rs;
    @(posedge clk);
    #1;
    if (rs) mdl_s = 0;
    else if (st) mdl_s = 1;
    else if (mdl_s > 0) mdl_s = mdl_s + 1;
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic probe(input int h, input int v);
    exp_t e;
    if (h < 0) h = 0;
    if (h > 1023) h = 1023;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    e.tag = n_probe;
    n_probe++;
    ref_pixel(h, v, mdl_rev(), mdl_bon(), e.vga, e.addr);
    ref_pixel(h, v, mdl_rev(), 1'b1, e.vga2, e.addr2);
    e.done = mdl_done();
    e.busy = (mdl_s > 0) && !e.done;
    sb.push_back(e);
  endtask

  task automatic probe_rand();
    int l;
    if ($urandom_range(0, 4) == 0) begin
      probe($urandom_range(0, 1023), $urandom_range(0, 1023));
    end else begin
      l = $urandom_range(0, NL - 1);
      probe(lhs[l] - 3 + $urandom_range(0, MC * GW + 5), lvs[l] - 2 + $urandom_range(0, GH + 4));
    end
  endtask

  task automatic probe_dir(input int i);
    case (i % 8)
      0: probe(115, 105);
      1: probe(130, 110);
      2: probe(145, 110);
      3: probe(115, 205);
      4: probe(100, 200);
      5: probe(102, 129);
      default: probe_rand();
    endcase
  endtask

  task automatic check(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s probe=%0d actual=%h expected=%h", nm, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("vga_data",       e.tag, 32'(vga1),  32'(e.vga));
      check("pixel_addr",     e.tag, 32'(addr1), 32'(e.addr));
      check("busy",           e.tag, 32'(busy1), 32'(e.busy));
      check("done",           e.tag, 32'(done1), 32'(e.done));
      check("noblink_vga",    e.tag, 32'(vga2),  32'(e.vga2));
      check("noblink_addr",   e.tag, 32'(addr2), 32'(e.addr2));
      check("noblink_done",   e.tag, 32'(done2), 32'(e.done));
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    h_cnt = '0;
    v_cnt = '0;
    chars[0] = '{3, 1, 20};
    chars[1] = '{4, 15, 7};
    lhs = '{100, 100};
    lvs = '{100, 200};
    apply_lines();

    tick(0, 1); probe(115, 105);
    tick(0, 1); probe(100, 200);
    for (int i = 0; i < 7; i++) begin tick(0, 0); probe_dir(i); end
    tick(1, 0); probe(100, 105);
    for (int i = 0; i < 48; i++) begin tick(0, 0); probe_dir(i); end

    // restart at revealed=4, then reset at revealed=3
    tick(1, 0); probe(100, 105);
    for (int k = 0; k < 40 && mdl_rev() != 4; k++) begin tick(0, 0); probe_dir(k); end
    tick(1, 0); probe(115, 105);
    tick(0, 0); probe(100, 105);
    for (int k = 0; k < 40 && mdl_rev() != 3; k++) begin tick(0, 0); probe_dir(k); end
    tick(0, 1); probe(100, 105);
    for (int i = 0; i < 3; i++) begin tick(0, 0); probe_dir(i); end

    for (int r = 0; r < 4; r++) begin
      for (int l = 0; l < NL; l++) begin
        for (int c = 0; c < MC; c++)
          chars[l][c] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 26);
        lhs[l] = ($urandom_range(0, 4) == 0) ? $urandom_range(980, 1020) : $urandom_range(0, 600);
        lvs[l] = $urandom_range(0, 460);
      end
      apply_lines();
      tick(0, 0); probe_rand();
      tick(1, 0); probe_rand();
      for (int i = 0; i < 45; i++) begin
        tick($urandom_range(0, 99) < 3, 0);
        probe_rand();
      end
      tick(0, 1); probe_rand();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 0, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
